immediate_pipe_unit: RTL

- Registered, parametrised successor to the combinational immediate generator.
- Decodes the instruction format from the opcode itself, so no external type input is needed.
- Produces an XLEN-wide immediate, the format code, the PC-relative target and an illegal flag.
- Sits between fetch and decode behind a valid/ready elastic buffer: 1-cycle latency, full throughput, supports flush.

---
 rtl/immediate_pipe_unit_pkg.sv | 26 ++
 rtl/immediate_pipe_unit_imm_decode.sv | 42 ++++
 rtl/immediate_pipe_unit.sv | 75 +++++++
 3 files changed

// File: rtl/immediate_pipe_unit_pkg.sv
// immediate_pipe_unit_pkg: format codes and opcode constants shared by the immediate pipe.
package immediate_pipe_unit_pkg;
  typedef enum logic [2:0] {
    I_TYPE    = 3'd0,
    S_TYPE    = 3'd1,
    B_TYPE    = 3'd2,
    U_TYPE    = 3'd3,
    J_TYPE    = 3'd4,
    R_TYPE    = 3'd5,
    Z_TYPE    = 3'd6,
    NONE_TYPE = 3'd7
  } fmt_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/immediate_pipe_unit_imm_decode.sv
// immediate_pipe_unit_imm_decode: combinational opcode-driven format, immediate and legality decode.
module immediate_pipe_unit_imm_decode
  import immediate_pipe_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1
) (
  input  logic [31:0]     instr_i,
  output fmt_t            type_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);
  localparam bit RV64 = (XLEN == 64);
  logic [6:0] op;
  logic       shift;
  assign op    = instr_i[6:0];
  assign shift = SHAMT_ZEXT && op == OP_IMM && instr_i[13:12] == 2'b01;
  always_comb begin
    type_o = NONE_TYPE;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: type_o = I_TYPE;
      OP_IMM32:                           type_o = RV64 ? I_TYPE : NONE_TYPE;
      OP_STORE:                           type_o = S_TYPE;
      OP_BRANCH:                          type_o = B_TYPE;
      OP_LUI, OP_AUIPC:                   type_o = U_TYPE;
      OP_JAL:                             type_o = J_TYPE;
      OP_REG:                             type_o = R_TYPE;
      OP_REG32:                           type_o = RV64 ? R_TYPE : NONE_TYPE;
      OP_SYSTEM:                          type_o = instr_i[14] ? Z_TYPE : I_TYPE;
      default:                            type_o = NONE_TYPE;
    endcase
  end
  // signed size casts perform the sign extension from inst[31]
  assign imm_o = shift              ? XLEN'({RV64 & instr_i[25], instr_i[24:20]}) :
                 type_o == I_TYPE   ? XLEN'($signed(instr_i[31:20])) :
                 type_o == S_TYPE   ? XLEN'($signed({instr_i[31:25], instr_i[11:7]})) :
                 type_o == B_TYPE   ? XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0})) :
                 type_o == U_TYPE   ? XLEN'($signed({instr_i[31:12], 12'b0})) :
                 type_o == J_TYPE   ? XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0})) :
                 type_o == Z_TYPE   ? XLEN'(instr_i[19:15]) : '0;
  assign illegal_o = type_o == NONE_TYPE || instr_i[1:0] != 2'b11 || (shift && !RV64 && instr_i[25]);
endmodule

// File: rtl/immediate_pipe_unit.sv
// immediate_pipe_unit: registered immediate decode behind a two-entry skid buffer with PC-relative target.
module immediate_pipe_unit
  import immediate_pipe_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);
  localparam int EW = 2 * XLEN + 4;
  fmt_t            dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic [EW-1:0]   dec_e, main_q, main_d, skid_q, skid_d;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic            accept, xfer;
  immediate_pipe_unit_imm_decode #(.XLEN(XLEN), .SHAMT_ZEXT(SHAMT_ZEXT)) u_dec (
    .instr_i   (in_instr),
    .type_o    (dec_type),
    .imm_o     (dec_imm),
    .illegal_o (dec_ill)
  );
  assign dec_e    = {dec_type, dec_ill, dec_imm, in_pc};
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign xfer     = main_valid_q && out_ready;
  // skid only fills while main is held, so it never holds data when main is empty
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || xfer) begin
      main_valid_d = skid_valid_q || accept;
      skid_valid_d = 1'b0;
      main_d       = skid_valid_q ? skid_q : accept ? dec_e : main_q;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = dec_e;
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
  assign {out_type, out_illegal, out_imm, out_pc} = main_q;
  assign out_valid  = main_valid_q;
  assign out_target = out_pc + out_imm;
endmodule
